// File: rtl/ex3_to_bin_serial.sv
// Serial excess-3 decoder: takes a packed word of excess-3 digits and decodes one digit per clock,
// MS digit first, producing the packed BCD word, its binary value and a sticky invalid-code flag.
module ex3_to_bin_serial #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] ex3_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e             state_q;
  logic [W-1:0]       shift_q;
  logic [W-1:0]       bcdAcc_q;
  logic [BIN_W-1:0]   binAcc_q;
  logic               errAcc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [3:0]         digitX;
  logic [3:0]         digitD;
  logic               digitOk;
  logic [W-1:0]       bcdAcc_d;
  logic [BIN_W-1:0]   binAcc_d;
  logic               errAcc_d;
  logic               lastDigit;

  // Single shared subtract-3 stage; invalid codes still land in the BCD word as raw x-3 mod 16
  // but contribute zero to the binary value.
  always_comb begin
    digitX    = shift_q[W-1 -: 4];
    digitD    = digitX + 4'b1101;
    digitOk   = (digitX >= 4'd3) && (digitX <= 4'd12);
    bcdAcc_d  = (bcdAcc_q << 4) | W'(digitD);
    binAcc_d  = (binAcc_q << 3) + (binAcc_q << 1) + (digitOk ? BIN_W'(digitD) : BIN_W'(0));
    errAcc_d  = errAcc_q | ~digitOk;
    lastDigit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcdAcc_q  <= '0;
      binAcc_q  <= '0;
      errAcc_q  <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      bin_out   <= '0;
      err       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q  <= ex3_in;
            bcdAcc_q <= '0;
            binAcc_q <= '0;
            errAcc_q <= 1'b0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= CONV;
          end
        end
        CONV: begin
          shift_q  <= shift_q << 4;
          bcdAcc_q <= bcdAcc_d;
          binAcc_q <= binAcc_d;
          errAcc_q <= errAcc_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Visible outputs only move on entry to DONE, so the previous result stays put meanwhile.
          if (lastDigit) begin
            bcd_out   <= bcdAcc_d;
            bin_out   <= binAcc_d;
            err       <= errAcc_d;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex3_to_bin_serial.sv
// Directed bench for ex3_to_bin_serial: an arithmetic decode model armed on every accepted word
// is compared against the outputs whenever out_valid is high, plus literal spot checks.
module tb_ex3_to_bin_serial;

  localparam int N     = 2;
  localparam int BIN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [4*N-1:0]   ex3_in;
  logic             in_valid;
  logic             in_ready;
  logic [4*N-1:0]   bcd_out;
  logic [BIN_W-1:0] bin_out;
  logic             err;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0] expBcd;
  logic [6:0] expBin;
  logic       expErr;
  logic       modelArmed = 1'b0;

  ex3_to_bin_serial #(.NUM_DIGITS(N), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .ex3_in(ex3_in), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_out(bcd_out), .bin_out(bin_out), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Decimal meaning of an excess-3 word: {err, bin, bcd}.
  function automatic logic [15:0] decodeWord(input logic [7:0] w);
    int bin = 0;
    logic e = 1'b0;
    logic [7:0] bcd = 8'h00;
    int x;
    int d;
    for (int k = N - 1; k >= 0; k--) begin
      x = (int'(w) >> (4 * k)) & 15;
      d = (x + 16 - 3) % 16;
      bcd = {bcd[3:0], 4'(d)};
      if (x >= 3 && x <= 12) bin = bin * 10 + (x - 3);
      else begin
        e = 1'b1;
        bin = bin * 10;
      end
    end
    return {e, 7'(bin), bcd};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Arm the model with every word the DUT actually accepts.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      {expErr, expBin, expBcd} = decodeWord(ex3_in);
      modelArmed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && modelArmed && out_valid) begin
      checkOutput("cmp_bcd", 32'(bcd_out), 32'(expBcd));
      checkOutput("cmp_bin", 32'(bin_out), 32'(expBin));
      checkOutput("cmp_err", 32'(err), 32'(expErr));
      checkOutput("cmp_in_ready_done", 32'(in_ready), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [7:0] w);
    int budget = 0;
    @(negedge clk);
    ex3_in   = w;
    in_valid = 1'b1;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    checkOutput("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic takeResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
  endtask

  task automatic runWord(input string name, input logic [7:0] w, input logic [7:0] bcdLit,
                         input logic [6:0] binLit, input logic errLit);
    int lat;
    applyStimulus(w);
    waitValid(lat);
    checkOutput({name, "_bcd"}, 32'(bcd_out), 32'(bcdLit));
    checkOutput({name, "_bin"}, 32'(bin_out), 32'(binLit));
    checkOutput({name, "_err"}, 32'(err), 32'(errLit));
    takeResult();
  endtask

  initial begin
    int lat;
    logic [7:0] sweep [6];
    rst = 1'b1; ex3_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    sweep = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h97, 8'hB6};

    // Pin the model itself to hand-computed values.
    checkOutput("model_48", 32'(decodeWord(8'h48)), 32'({1'b0, 7'd15, 8'h15}));
    checkOutput("model_2A", 32'(decodeWord(8'h2A)), 32'({1'b1, 7'd7, 8'hF7}));
    checkOutput("model_4F", 32'(decodeWord(8'h4F)), 32'({1'b1, 7'd10, 8'h1C}));
    checkOutput("model_CC", 32'(decodeWord(8'hCC)), 32'({1'b0, 7'd99, 8'h99}));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
    checkOutput("rst_bin", 32'(bin_out), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    applyStimulus(8'h48);
    waitValid(lat);
    checkOutput("t1_latency", 32'(lat), 32'd3);
    checkOutput("t1_bcd", 32'(bcd_out), 32'h15);
    checkOutput("t1_bin", 32'(bin_out), 32'd15);
    checkOutput("t1_err", 32'(err), 32'd0);
    takeResult();
    checkOutput("t1_hold_after_take", 32'(bin_out), 32'd15);

    runWord("t2", 8'h33, 8'h00, 7'd0, 1'b0);
    runWord("t3", 8'hCC, 8'h99, 7'd99, 1'b0);
    runWord("t4a", 8'h2A, 8'hF7, 7'd7, 1'b1);
    runWord("t4b", 8'h4F, 8'h1C, 7'd10, 1'b1);

    // Result stalled by downstream while a second word waits on in_valid.
    applyStimulus(8'h48);
    waitValid(lat);
    ex3_in   = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t5_hold_bcd", 32'(bcd_out), 32'h15);
      checkOutput("t5_hold_bin", 32'(bin_out), 32'd15);
      checkOutput("t5_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkOutput("t5_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("t5_ready_next", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_accepted", 32'(in_ready), 32'd0);
    waitValid(lat);
    checkOutput("t5_second_bcd", 32'(bcd_out), 32'h00);
    checkOutput("t5_second_bin", 32'(bin_out), 32'd0);
    takeResult();

    // Abort mid-conversion.
    applyStimulus(8'h5B);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_bcd", 32'(bcd_out), 32'd0);
    checkOutput("t6_bin", 32'(bin_out), 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_no_partial", 32'(out_valid), 32'd0);
    end
    runWord("t6b", 8'h5B, 8'h28, 7'd28, 1'b0);

    // Further patterns checked against the model by the compare process.
    foreach (sweep[i]) begin
      applyStimulus(sweep[i]);
      waitValid(lat);
      takeResult();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
